// File: rtl/line_packer.sv
// line_packer: frames a 16-bit sample stream into scan lines
// (sync word, line number, samples, checksum) and serialises each line
// MSB-first onto a byte-wide FIFO write port. The sample source is paced
// through its active-low enable so exactly one sample is taken per slot.
module line_packer #(
  parameter int          SAMPLES_PER_LINE = 256,
  parameter logic [15:0] HEADER           = 16'hA55A
) (
  input  logic        CLK,
  input  logic        nCLR,
  input  logic        START,
  input  logic [15:0] DIN,
  output logic        nEN_OUT,
  input  logic        nTXE,
  output logic        WR,
  output logic [7:0]  BYTE_OUT,
  output logic        BUSY,
  output logic        LINE_DONE,
  output logic [7:0]  LINE_CNT
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] HDR_H = 4'd1;
  localparam logic [3:0] HDR_L = 4'd2;
  localparam logic [3:0] ID_H  = 4'd3;
  localparam logic [3:0] ID_L  = 4'd4;
  localparam logic [3:0] DAT_H = 4'd5;
  localparam logic [3:0] DAT_L = 4'd6;
  localparam logic [3:0] SUM_H = 4'd7;
  localparam logic [3:0] SUM_L = 4'd8;

  localparam logic [15:0] LAST_SAMPLE = 16'(SAMPLES_PER_LINE);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [15:0] smp_cnt;
  logic [15:0] csum;
  logic [15:0] hold;
  logic        xfer;

  // Checksum accumulation wraps modulo 2^16; the carry is discarded.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0];
  endfunction

  assign BUSY    = (state != IDLE);
  assign WR      = BUSY & ~nTXE;
  assign xfer    = WR;
  // The counter advances on the same edge that ships the sample's high byte.
  assign nEN_OUT = (state == DAT_H) ? nTXE : 1'b1;

  // Next-state: every transmit state advances only when its byte transfers.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = HDR_H;
      HDR_H:   if (xfer)  state_nxt = HDR_L;
      HDR_L:   if (xfer)  state_nxt = ID_H;
      ID_H:    if (xfer)  state_nxt = ID_L;
      ID_L:    if (xfer)  state_nxt = DAT_H;
      DAT_H:   if (xfer)  state_nxt = DAT_L;
      DAT_L:   if (xfer)  state_nxt = (smp_cnt == LAST_SAMPLE) ? SUM_H : DAT_H;
      SUM_H:   if (xfer)  state_nxt = SUM_L;
      SUM_L:   if (xfer)  state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // Byte offered in each state; the high data byte comes straight from DIN.
  always_comb begin
    BYTE_OUT = 8'h00;
    case (state)
      HDR_H:   BYTE_OUT = HEADER[15:8];
      HDR_L:   BYTE_OUT = HEADER[7:0];
      ID_H:    BYTE_OUT = 8'h00;
      ID_L:    BYTE_OUT = LINE_CNT;
      DAT_H:   BYTE_OUT = DIN[15:8];
      DAT_L:   BYTE_OUT = hold[7:0];
      SUM_H:   BYTE_OUT = csum[15:8];
      SUM_L:   BYTE_OUT = csum[7:0];
      default: BYTE_OUT = 8'h00;
    endcase
  end

  // State register and end-of-line pulse.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state     <= IDLE;
      LINE_DONE <= 1'b0;
    end else begin
      state     <= state_nxt;
      LINE_DONE <= (state == SUM_L) && xfer;
    end
  end

  // Sample capture, checksum and sample count; cleared when a line starts.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      smp_cnt <= 16'd0;
      csum    <= 16'd0;
      hold    <= 16'd0;
    end else if (state == IDLE && START) begin
      smp_cnt <= 16'd0;
      csum    <= 16'd0;
    end else if (state == DAT_H && xfer) begin
      hold    <= DIN;
      csum    <= csum_add(csum, DIN);
      smp_cnt <= smp_cnt + 16'd1;
    end
  end

  // Completed-line counter; the line-number byte uses the value before this bump.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      LINE_CNT <= 8'd0;
    end else if (state == SUM_L && xfer) begin
      LINE_CNT <= LINE_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_line_packer.sv
// tb_line_packer: directed bench for line_packer with three instances
// (4, 2 and 1 samples per line) and a sample-counter model on the first.
module tb_line_packer;

  logic       CLK = 1'b0;
  logic       nCLR;
  logic       start_a, start_b, start_c;
  logic       ntxe_a, ntxe_b, ntxe_c;
  logic [15:0] din_a, din_b, din_c;
  logic       nen_a, nen_b, nen_c;
  logic       wr_a, wr_b, wr_c;
  logic [7:0] byte_a, byte_b, byte_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] lcnt_a, lcnt_b, lcnt_c;

  logic [15:0] ctr_a;
  logic        idx_b;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  qc[$];
  int          nen_low_a = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_buf [0:15];

  always #5 CLK = ~CLK;

  line_packer #(.SAMPLES_PER_LINE(4), .HEADER(16'hA55A)) u_a (
    .CLK(CLK), .nCLR(nCLR), .START(start_a), .DIN(din_a), .nEN_OUT(nen_a),
    .nTXE(ntxe_a), .WR(wr_a), .BYTE_OUT(byte_a), .BUSY(busy_a),
    .LINE_DONE(done_a), .LINE_CNT(lcnt_a));

  line_packer #(.SAMPLES_PER_LINE(2), .HEADER(16'hA55A)) u_b (
    .CLK(CLK), .nCLR(nCLR), .START(start_b), .DIN(din_b), .nEN_OUT(nen_b),
    .nTXE(ntxe_b), .WR(wr_b), .BYTE_OUT(byte_b), .BUSY(busy_b),
    .LINE_DONE(done_b), .LINE_CNT(lcnt_b));

  line_packer #(.SAMPLES_PER_LINE(1), .HEADER(16'hA55A)) u_c (
    .CLK(CLK), .nCLR(nCLR), .START(start_c), .DIN(din_c), .nEN_OUT(nen_c),
    .nTXE(ntxe_c), .WR(wr_c), .BYTE_OUT(byte_c), .BUSY(busy_c),
    .LINE_DONE(done_c), .LINE_CNT(lcnt_c));

  // Sample-counter model driving instance a: counts while nEN is low.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR)      ctr_a <= 16'd0;
    else if (!nen_a) ctr_a <= ctr_a + 16'd1;
  end
  assign din_a = ctr_a;

  // Two-entry sample source for instance b: FFFF then 0002.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR)      idx_b <= 1'b0;
    else if (!nen_b) idx_b <= ~idx_b;
  end
  assign din_b = idx_b ? 16'h0002 : 16'hFFFF;
  assign din_c = 16'h1234;

  // Byte monitor: log every byte that will transfer on the next rising edge.
  always @(negedge CLK) begin
    if (wr_a) qa.push_back(byte_a);
    if (wr_b) qb.push_back(byte_b);
    if (wr_c) qc.push_back(byte_c);
    if (!nen_a) nen_low_a = nen_low_a + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    if (sel == 0) return qa.size();
    if (sel == 1) return qb.size();
    return qc.size();
  endfunction

  function automatic logic [7:0] byte_at(input int sel, input int idx);
    if (idx >= qsize(sel)) return 8'hxx;
    if (sel == 0) return qa[idx];
    if (sel == 1) return qb[idx];
    return qc[idx];
  endfunction

  task automatic cmp_stream(input string tag, input int sel, input int base, input int n);
    chk({tag, "_len"}, 32'(qsize(sel) - base), 32'(n));
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_b%0d", tag, k), {24'd0, byte_at(sel, base + k)}, {24'd0, exp_buf[k]});
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start_a = 1'b1;
    else if (sel == 1) start_b = 1'b1;
    else start_c = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int sel, output int n);
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < 2000) begin
      tick();
      n++;
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    end
    chk({tag, "_done"}, {31'd0, d}, 32'd1);
  endtask

  task automatic do_reset();
    nCLR = 1'b0;
    tick();
    nCLR = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int base;
    int nb;
    nCLR = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ntxe_a = 1'b0;  ntxe_b = 1'b0;  ntxe_c = 1'b0;
    #3;
    // Reset values while held in reset, with space available.
    chk("rst_nen",  {31'd0, nen_a},  32'd1);
    chk("rst_wr",   {31'd0, wr_a},   32'd0);
    chk("rst_byte", {24'd0, byte_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_lcnt", {24'd0, lcnt_a}, 32'd0);
    @(posedge CLK);
    #1;
    nCLR = 1'b1;
    tick();

    // Basic line, four counter samples.
    base = qa.size();
    nb = nen_low_a;
    pulse_start(0);
    wait_done("s2", 0, n);
    chk("s2_cycles", 32'(n), 32'd14);
    exp_buf = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h06, 8'h00, 8'h00};
    cmp_stream("s2", 0, base, 14);
    chk("s2_lcnt", {24'd0, lcnt_a}, 32'd1);
    chk("s2_ctr",  {16'd0, ctr_a}, 32'd4);
    chk("s2_nen",  32'(nen_low_a - nb), 32'd4);
    chk("s2_busy", {31'd0, busy_a}, 32'd0);
    tick();
    chk("s2_done_clr", {31'd0, done_a}, 32'd0);

    // Asynchronous reset in the middle of DAT_L.
    pulse_start(0);
    repeat (5) tick();
    chk("s1_busy_pre", {31'd0, busy_a}, 32'd1);
    chk("s1_wr_pre",   {31'd0, wr_a},   32'd1);
    #2;
    nCLR = 1'b0;
    #1;
    chk("s1_nen",  {31'd0, nen_a},  32'd1);
    chk("s1_wr",   {31'd0, wr_a},   32'd0);
    chk("s1_busy", {31'd0, busy_a}, 32'd0);
    chk("s1_byte", {24'd0, byte_a}, 32'd0);
    chk("s1_lcnt", {24'd0, lcnt_a}, 32'd0);
    chk("s1_done", {31'd0, done_a}, 32'd0);
    @(posedge CLK);
    #1;
    nCLR = 1'b1;
    tick();

    // Back-pressure in HDR_L and in DAT_H of sample 2.
    base = qa.size();
    nb = nen_low_a;
    pulse_start(0);
    tick();
    ntxe_a = 1'b1;
    #1;
    chk("s3_wr_hdr",  {31'd0, wr_a},  32'd0);
    chk("s3_nen_hdr", {31'd0, nen_a}, 32'd1);
    repeat (3) tick();
    ntxe_a = 1'b0;
    repeat (7) tick();
    chk("s3_ctr_pre", {16'd0, ctr_a}, 32'd2);
    ntxe_a = 1'b1;
    #1;
    chk("s3_wr_dat",  {31'd0, wr_a},  32'd0);
    chk("s3_nen_dat", {31'd0, nen_a}, 32'd1);
    repeat (3) tick();
    chk("s3_ctr_hold", {16'd0, ctr_a}, 32'd2);
    ntxe_a = 1'b0;
    wait_done("s3", 0, n);
    chk("s3_cycles", 32'(n), 32'd6);
    exp_buf = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h06, 8'h00, 8'h00};
    cmp_stream("s3", 0, base, 14);
    chk("s3_nen", 32'(nen_low_a - nb), 32'd4);
    chk("s3_lcnt", {24'd0, lcnt_a}, 32'd1);

    // Checksum wrap: FFFF + 0002 = 0001.
    do_reset();
    base = qb.size();
    pulse_start(1);
    wait_done("s4", 1, n);
    chk("s4_cycles", 32'(n), 32'd10);
    exp_buf = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h02,
                8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cmp_stream("s4", 1, base, 10);

    // START ignored mid-line, accepted in the LINE_DONE cycle.
    do_reset();
    base = qa.size();
    pulse_start(0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done("s5a", 0, n);
    chk("s5a_cycles", 32'(n), 32'd8);
    exp_buf = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h06, 8'h00, 8'h00};
    cmp_stream("s5a", 0, base, 14);
    chk("s5_idle", {31'd0, busy_a}, 32'd0);
    pulse_start(0);
    chk("s5_restart", {31'd0, busy_a}, 32'd1);
    wait_done("s5b", 0, n);
    chk("s5b_cycles", 32'(n), 32'd14);
    exp_buf = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h05,
                8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h16, 8'h00, 8'h00};
    cmp_stream("s5b", 0, base + 14, 14);
    chk("s5_lcnt", {24'd0, lcnt_a}, 32'd2);

    // LINE_CNT wrap over 257 one-sample lines.
    do_reset();
    exp_buf = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h12, 8'h34, 8'h12, 8'h34,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 257; i++) begin
      base = qc.size();
      pulse_start(2);
      wait_done($sformatf("s6_l%0d", i), 2, n);
      if (i == 0) cmp_stream("s6_first", 2, base, 8);
      if (i == 254) chk("s6_lcnt_255", {24'd0, lcnt_c}, 32'd255);
      if (i == 255) begin
        chk("s6_id_ff",   {24'd0, byte_at(2, base + 3)}, 32'hFF);
        chk("s6_lcnt_0",  {24'd0, lcnt_c}, 32'd0);
      end
      if (i == 256) begin
        chk("s6_id_00",   {24'd0, byte_at(2, base + 3)}, 32'h00);
        chk("s6_lcnt_1",  {24'd0, lcnt_c}, 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
